fifo_v4_initialized_mp: RTL and testbench

- Multi-port successor of the single-port initialized FIFO used as a free-list (IDs, MSHR slots, write-buffer tags) in the cache subsystem.
- Comes out of reset and flush full, preloaded with a per-entry value vector.
- Up to PUSH_PORTS returns and POP_PORTS allocations per cycle.
- Full-width occupancy output, plus almost-full/almost-empty watermarks.

---
 rtl/fifo_init_pkg.sv | 43 ++++
 rtl/fifo_init_lane_alloc.sv | 48 ++++
 rtl/fifo_v4_initialized_mp.sv | 164 ++++++++++++++++
 tb/tb_fifo_v4_initialized_mp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_init_pkg.sv
// ----------------------------------------------------------------------------
// fifo_init_pkg
// Shared helpers for the initialised multi-port free-list FIFO family.
//   cnt_width(depth) : occupancy counter width, able to hold 0..depth
//   ptr_width(depth) : pointer width for indices 0..depth-1 (at least 1 bit)
//   ptr_add(p,i,d)   : (p + i) mod d by compare-and-subtract, for p < d, i <= d
//   popcount(vec)    : number of set bits in a lane vector (up to MAX_LANES)
// ----------------------------------------------------------------------------
package fifo_init_pkg;

    localparam int unsigned MAX_LANES = 64;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Both operands are bounded by depth, so one conditional subtract is
    // enough and depth need not be a power of two.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_init_lane_alloc.sv
// ----------------------------------------------------------------------------
// fifo_init_lane_alloc
// Combinational push-lane allocator. Requests are granted in lane order while
// the running count of requests fits in the available space; granted lanes
// are packed into consecutive slots.
// Ports:
//   push        in   per-lane push request (may be sparse)
//   space       in   free entries available this cycle
//   push_ready  out  per-lane grant
//   offset      out  per-lane slot offset from the write pointer (granted lanes)
//   npush       out  number of granted lanes
// ----------------------------------------------------------------------------
module fifo_init_lane_alloc
    import fifo_init_pkg::*;
#(
    parameter int unsigned PUSH_PORTS = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic [PUSH_PORTS-1:0]            push,
    input  logic [CNT_W-1:0]                 space,
    output logic [PUSH_PORTS-1:0]            push_ready,
    output logic [PUSH_PORTS-1:0][CNT_W-1:0] offset,
    output logic [CNT_W-1:0]                 npush
);

    // A lane is granted when the number of requests up to and including it
    // fits in space; its slot is the number of granted lanes below it.
    always_comb begin : alloc
        int unsigned requested;
        int unsigned room;
        requested  = 0;
        room       = 32'(space);
        push_ready = '0;
        offset     = '0;
        for (int k = 0; k < int'(PUSH_PORTS); k++) begin
            if (push[k]) begin
                requested = requested + 1;
                if (requested <= room) begin
                    push_ready[k] = 1'b1;
                    offset[k]     = CNT_W'(requested - 1);
                end
            end
        end
    end

    assign npush = CNT_W'(popcount(MAX_LANES'(push_ready)));

endmodule

// File: rtl/fifo_v4_initialized_mp.sv
// ----------------------------------------------------------------------------
// fifo_v4_initialized_mp
// Multi-port free-list FIFO that starts full with a preloaded value per entry
// after reset or flush. Up to PUSH_PORTS returns and POP_PORTS allocations per
// cycle; pop data is read combinationally from the storage array.
// Optional macro: FIFO_V4_INIT_ERR_FLAGS_EN builds sticky overflow/underflow
// flags; without it both error outputs are tied low.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync re-initialise)
//   reset_value_i  contents loaded on reset/flush, entry k in slice k
//   push_i/data_i/push_ready_o   push lanes
//   pop_i/valid_o/data_o         pop lanes (pop_i is thermometer-coded)
//   usage_o, full_o, empty_o, almost_full_o, almost_empty_o   status
//   err_overflow_o, err_underflow_o                           sticky errors
// ----------------------------------------------------------------------------
module fifo_v4_initialized_mp
    import fifo_init_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PUSH_PORTS = 2,
    parameter int unsigned POP_PORTS  = 2,
    parameter int unsigned AF_THRESH  = DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned CNT_W      = cnt_width(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic [DEPTH*DATA_WIDTH-1:0]      reset_value_i,
    input  logic [PUSH_PORTS-1:0]            push_i,
    input  logic [PUSH_PORTS*DATA_WIDTH-1:0] data_i,
    output logic [PUSH_PORTS-1:0]            push_ready_o,
    input  logic [POP_PORTS-1:0]             pop_i,
    output logic [POP_PORTS-1:0]             valid_o,
    output logic [POP_PORTS*DATA_WIDTH-1:0]  data_o,
    output logic [CNT_W-1:0]                 usage_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             almost_full_o,
    output logic                             almost_empty_o,
    output logic                             err_overflow_o,
    output logic                             err_underflow_o
);

    localparam int unsigned      PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]                 rd_ptr_q;
    logic [PTR_W-1:0]                 wr_ptr_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic [CNT_W-1:0]                 space;
    logic [CNT_W-1:0]                 npush;
    logic [CNT_W-1:0]                 npop;
    logic [PUSH_PORTS-1:0][CNT_W-1:0] wr_offset;
    logic [PTR_W-1:0]                 wr_idx [PUSH_PORTS];
    logic [PTR_W-1:0]                 rd_idx [POP_PORTS];
    logic [POP_PORTS-1:0]             pop_take;

    // Space comes from the registered count only, so a pop in the same
    // cycle never makes room for a push.
    assign space = DEPTH_C - cnt_q;

    fifo_init_lane_alloc #(
        .PUSH_PORTS (PUSH_PORTS),
        .CNT_W      (CNT_W)
    ) u_lane_alloc (
        .push       (push_i),
        .space      (space),
        .push_ready (push_ready_o),
        .offset     (wr_offset),
        .npush      (npush)
    );

    always_comb begin
        for (int k = 0; k < int'(PUSH_PORTS); k++) begin
            wr_idx[k] = PTR_W'(ptr_add(32'(wr_ptr_q), 32'(wr_offset[k]), DEPTH));
        end
    end

    // Pop lane k shows the entry k places after the read pointer; a request
    // on a lane without data is simply not taken.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < int'(POP_PORTS); k++) begin
            rd_idx[k]  = PTR_W'(ptr_add(32'(rd_ptr_q), 32'(k), DEPTH));
            valid_o[k] = (cnt_q > CNT_W'(k));
            data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_idx[k]];
        end
    end

    assign pop_take = pop_i & valid_o;
    assign npop     = CNT_W'(popcount(MAX_LANES'(pop_take)));

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= DEPTH_C;
        end else begin
            rd_ptr_q <= PTR_W'(ptr_add(32'(rd_ptr_q), 32'(npop), DEPTH));
            wr_ptr_q <= PTR_W'(ptr_add(32'(wr_ptr_q), 32'(npush), DEPTH));
            cnt_q    <= cnt_q + npush - npop;
        end
    end

    // Storage is reloaded wholesale on reset/flush; otherwise only granted
    // lanes write, each into its packed slot.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= reset_value_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int k = 0; k < int'(PUSH_PORTS); k++) begin
                if (push_ready_o[k]) begin
                    mem_q[wr_idx[k]] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign usage_o        = cnt_q;
    assign full_o         = (cnt_q == DEPTH_C);
    assign empty_o        = (cnt_q == '0);
    assign almost_full_o  = (cnt_q >= AF_C);
    assign almost_empty_o = (cnt_q <= AE_C);

`ifdef FIFO_V4_INIT_ERR_FLAGS_EN
    logic err_overflow_q;
    logic err_underflow_q;
    logic overflow_evt;
    logic underflow_evt;

    assign overflow_evt  = |(push_i & ~push_ready_o);
    assign underflow_evt = |(pop_i & ~valid_o);

    // Sticky until reset; flush keeps the history and its own cycle's
    // requests are ignored, so they cannot raise an error either.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else if (!flush_i) begin
            if (overflow_evt) begin
                err_overflow_q <= 1'b1;
            end
            if (underflow_evt) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    assign err_overflow_o  = err_overflow_q;
    assign err_underflow_o = err_underflow_q;
`else
    assign err_overflow_o  = 1'b0;
    assign err_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_v4_initialized_mp.sv
// ----------------------------------------------------------------------------
// tb_fifo_v4_initialized_mp
// Self-checking bench: a DEPTH=8 instance checked every cycle against a
// queue-based model, plus a DEPTH=5 instance for pointer wrap-around.
// ----------------------------------------------------------------------------
module tb_fifo_v4_initialized_mp;

    localparam int DW  = 32;
    localparam int D   = 8;
    localparam int PP  = 2;
    localparam int QP  = 2;
    localparam int CW  = 4;
    localparam int D5  = 5;
    localparam int CW5 = 3;
`ifdef FIFO_V4_INIT_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush;
    logic [D*DW-1:0]   reset_value;
    logic [PP-1:0]     push;
    logic [PP*DW-1:0]  data;
    logic [PP-1:0]     push_ready;
    logic [QP-1:0]     pop;
    logic [QP-1:0]     valid;
    logic [QP*DW-1:0]  data_o;
    logic [CW-1:0]     usage;
    logic              full, empty, afull, aempty, err_ovf, err_unf;

    logic              rst5, flush5;
    logic [D5*DW-1:0]  reset_value5;
    logic [PP-1:0]     push5;
    logic [PP*DW-1:0]  data5;
    logic [PP-1:0]     push_ready5;
    logic [QP-1:0]     pop5;
    logic [QP-1:0]     valid5;
    logic [QP*DW-1:0]  data_o5;
    logic [CW5-1:0]    usage5;
    logic              full5, empty5, afull5, aempty5, err_ovf5, err_unf5;

    fifo_v4_initialized_mp #(.DATA_WIDTH(DW), .DEPTH(D), .PUSH_PORTS(PP), .POP_PORTS(QP)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .reset_value_i(reset_value),
        .push_i(push), .data_i(data), .push_ready_o(push_ready),
        .pop_i(pop), .valid_o(valid), .data_o(data_o), .usage_o(usage),
        .full_o(full), .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty),
        .err_overflow_o(err_ovf), .err_underflow_o(err_unf)
    );

    fifo_v4_initialized_mp #(.DATA_WIDTH(DW), .DEPTH(D5), .PUSH_PORTS(PP), .POP_PORTS(QP)) dut5 (
        .clk_i(clk), .rst_i(rst5), .flush_i(flush5), .reset_value_i(reset_value5),
        .push_i(push5), .data_i(data5), .push_ready_o(push_ready5),
        .pop_i(pop5), .valid_o(valid5), .data_o(data_o5), .usage_o(usage5),
        .full_o(full5), .empty_o(empty5), .almost_full_o(afull5), .almost_empty_o(aempty5),
        .err_overflow_o(err_ovf5), .err_underflow_o(err_unf5)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit checkEn    = 1'b0;

    // Reference model: the FIFO contents as a plain queue, head first.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] acc[$];
    bit mErrO = 1'b0;
    bit mErrU = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic [PP-1:0] pu,
                                 input logic [PP*DW-1:0] d, input logic [QP-1:0] po);
        @(posedge clk);
        #2;
        rst   = r;
        flush = f;
        push  = pu;
        data  = d;
        pop   = po;
    endtask

    // Model update from the inputs that were stable across this edge.
    always @(posedge clk) begin : model
        int sz;
        int room;
        int req;
        int np;
        if (rst || flush) begin
            mq.delete();
            for (int k = 0; k < D; k++) mq.push_back(reset_value[k*DW +: DW]);
            if (rst) begin
                mErrO = 1'b0;
                mErrU = 1'b0;
            end
        end else begin
            sz   = mq.size();
            room = D - sz;
            req  = 0;
            np   = 0;
            acc.delete();
            for (int k = 0; k < PP; k++) begin
                if (push[k]) begin
                    req++;
                    if (req <= room) acc.push_back(data[k*DW +: DW]);
                    else mErrO = 1'b1;
                end
            end
            for (int k = 0; k < QP; k++) begin
                if (pop[k]) begin
                    if (k < sz) np++;
                    else mErrU = 1'b1;
                end
            end
            for (int k = 0; k < np; k++) void'(mq.pop_front());
            foreach (acc[i]) mq.push_back(acc[i]);
        end
    end

    // Every-cycle comparison of all DEPTH=8 outputs against the model.
    always @(negedge clk) begin : compare
        int sz;
        int req;
        logic [PP-1:0] expReady;
        if (checkEn) begin
            sz = mq.size();
            checkOutput("usage", 64'(usage), 64'(sz));
            checkOutput("full", 64'(full), 64'(sz == D));
            checkOutput("empty", 64'(empty), 64'(sz == 0));
            checkOutput("almost_full", 64'(afull), 64'(sz >= D - 1));
            checkOutput("almost_empty", 64'(aempty), 64'(sz <= 1));
            for (int k = 0; k < QP; k++) begin
                checkOutput("valid", 64'(valid[k]), 64'(sz > k));
                if (sz > k) checkOutput("data_lane", 64'(data_o[k*DW +: DW]), 64'(mq[k]));
            end
            req = 0;
            expReady = '0;
            for (int k = 0; k < PP; k++) begin
                if (push[k]) begin
                    req++;
                    expReady[k] = (req <= D - sz);
                end
            end
            checkOutput("push_ready", 64'(push_ready), 64'(expReady));
            checkOutput("err_overflow", 64'(err_ovf), 64'(ERR_EN & mErrO));
            checkOutput("err_underflow", 64'(err_unf), 64'(ERR_EN & mErrU));
        end
    end

    initial begin
        logic [DW-1:0] rv0;
        rst = 1'b1; flush = 1'b0; push = '0; data = '0; pop = '0;
        rst5 = 1'b1; flush5 = 1'b0; push5 = '0; data5 = '0; pop5 = '0;
        for (int k = 0; k < D; k++) reset_value[k*DW +: DW] = DW'(k);
        for (int k = 0; k < D5; k++) reset_value5[k*DW +: DW] = DW'(k);

        // DEPTH=5: drain four, push A sparse then B,C, drain across the wrap.
        @(posedge clk); #2; rst5 = 1'b0; pop5 = 2'b11;
        @(negedge clk);
        checkOutput("d5_usage_reset", 64'(usage5), 64'd5);
        checkOutput("d5_full_reset", 64'(full5), 64'd1);
        checkOutput("d5_err_reset", 64'({err_ovf5, err_unf5}), 64'd0);
        checkOutput("d5_pair0", 64'(data_o5), 64'h00000001_00000000);
        @(posedge clk); #2;
        @(negedge clk);
        checkOutput("d5_usage3", 64'(usage5), 64'd3);
        checkOutput("d5_pair1", 64'(data_o5), 64'h00000003_00000002);
        @(posedge clk); #2; pop5 = 2'b00; push5 = 2'b10; data5 = {32'hAAAA_000A, 32'hDEAD_BEEF};
        @(negedge clk);
        checkOutput("d5_usage1", 64'(usage5), 64'd1);
        checkOutput("d5_valid1", 64'(valid5), 64'd1);
        checkOutput("d5_lane0_4", 64'(data_o5[DW-1:0]), 64'd4);
        checkOutput("d5_ready_sparse", 64'(push_ready5), 64'b10);
        @(posedge clk); #2; push5 = 2'b11; data5 = {32'hCCCC_000C, 32'hBBBB_000B};
        @(negedge clk);
        checkOutput("d5_usage2", 64'(usage5), 64'd2);
        checkOutput("d5_ready_both", 64'(push_ready5), 64'b11);
        @(posedge clk); #2; push5 = 2'b00; pop5 = 2'b11;
        @(negedge clk);
        checkOutput("d5_usage4", 64'(usage5), 64'd4);
        checkOutput("d5_afull4", 64'(afull5), 64'd1);
        checkOutput("d5_pair_wrap", 64'(data_o5), 64'hAAAA_000A_00000004);
        @(posedge clk); #2;
        @(negedge clk);
        checkOutput("d5_pair_bc", 64'(data_o5), 64'hCCCC_000C_BBBB_000B);
        @(posedge clk); #2; pop5 = 2'b00;
        @(negedge clk);
        checkOutput("d5_empty", 64'(empty5), 64'd1);
        checkOutput("d5_aempty", 64'(aempty5), 64'd1);

        // DEPTH=8 reset contents popped in pairs.
        @(posedge clk); #2; rst = 1'b0; pop = 2'b11; checkEn = 1'b1;
        @(negedge clk);
        checkOutput("lit_usage8", 64'(usage), 64'd8);
        checkOutput("lit_full", 64'(full), 64'd1);
        checkOutput("lit_empty0", 64'(empty), 64'd0);
        checkOutput("lit_valid", 64'(valid), 64'b11);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #2;
                @(negedge clk);
            end
            checkOutput("lit_usage_drain", 64'(usage), 64'(8 - 2 * i));
            checkOutput("lit_pair", 64'(data_o), {32'(2 * i + 1), 32'(2 * i)});
        end
        @(posedge clk); #2; pop = 2'b00;
        @(negedge clk);
        checkOutput("lit_usage0", 64'(usage), 64'd0);
        checkOutput("lit_empty1", 64'(empty), 64'd1);

        // Underflow: one entry, both lanes popped.
        applyStimulus(1'b0, 1'b0, 2'b01, {32'h0, 32'h1234_5678}, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b11);
        @(negedge clk);
        checkOutput("lit_usage1", 64'(usage), 64'd1);
        checkOutput("lit_aempty1", 64'(aempty), 64'd1);
        checkOutput("lit_lane0_pushed", 64'(data_o[DW-1:0]), 64'h1234_5678);
        checkOutput("lit_unf_before", 64'(err_unf), 64'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b00);
        @(negedge clk);
        checkOutput("lit_unf_after", 64'(err_unf), 64'(ERR_EN));
        checkOutput("lit_empty_after_unf", 64'(empty), 64'd1);

        // Overflow at full with a concurrent pop.
        applyStimulus(1'b1, 1'b0, 2'b00, '0, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b11, {32'h5555_5555, 32'h4444_4444}, 2'b01);
        @(negedge clk);
        checkOutput("lit_ready_full", 64'(push_ready), 64'b00);
        checkOutput("lit_unf_reset", 64'(err_unf), 64'd0);
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b00);
        @(negedge clk);
        checkOutput("lit_usage7", 64'(usage), 64'd7);
        checkOutput("lit_ovf", 64'(err_ovf), 64'(ERR_EN));

        // Flush mid-traffic with pushes asserted, new reload contents.
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b11);
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b11);
        for (int k = 0; k < D; k++) reset_value[k*DW +: DW] = $urandom;
        rv0 = reset_value[DW-1:0];
        applyStimulus(1'b0, 1'b1, 2'b11, {32'h7777_7777, 32'h6666_6666}, 2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b00);
        @(negedge clk);
        checkOutput("lit_flush_usage", 64'(usage), 64'd8);
        checkOutput("lit_flush_lane0", 64'(data_o[DW-1:0]), 64'(rv0));
        checkOutput("lit_flush_keeps_ovf", 64'(err_ovf), 64'(ERR_EN));

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            logic r;
            logic f;
            int npo;
            r   = ($urandom_range(999) == 0);
            f   = ($urandom_range(299) == 0);
            npo = $urandom_range(2);
            if ($urandom_range(499) == 0) begin
                for (int k = 0; k < D; k++) reset_value[k*DW +: DW] = $urandom;
            end
            applyStimulus(r, f, PP'($urandom), {$urandom, $urandom}, QP'((1 << npo) - 1));
        end
        applyStimulus(1'b0, 1'b0, 2'b00, '0, 2'b00);
        @(negedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
